// File: rtl/uop_sequencer.sv
// Microoperation sequencer: drives uOP for the microcoded controller, latches ALU flags,
// and provides run/halt/single-step control with a retire counter. Optional macro: UOP_WATCHDOG_EN.
module uop_sequencer #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned UOP_LIMIT = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RUN,
  input  logic             STEP_REQ,
  input  logic             RESET_uOP,
  input  logic             READ_FLAGS,
  input  logic             ALU_ZERO,
  input  logic             ALU_COUT,
  output logic [2:0]       uOP,
  output logic             ZERO_FLAG,
  output logic             COUT_FLAG,
  output logic             HALTED,
  output logic             STEP_ACK,
  output logic             INSTR_DONE,
  output logic [CNT_W-1:0] INSTR_COUNT,
  output logic             UOP_ERR
);

  localparam int unsigned UOP_W    = 3;
  localparam logic [UOP_W-1:0] UOP_IDLE  = UOP_W'(7);
  localparam logic [UOP_W-1:0] UOP_FIRST = UOP_W'(0);

`ifdef UOP_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT,
    S_STEP
  } state_t;

  state_t state;

  // Runaway microcode: highest allowed uOP reached without the controller ending the instruction.
  logic at_limit;
  logic wd_trip;
  assign at_limit = (uOP == UOP_W'(UOP_LIMIT));
  assign wd_trip  = WD_EN && at_limit && !RESET_uOP;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      uOP         <= UOP_IDLE;
      ZERO_FLAG   <= 1'b0;
      COUT_FLAG   <= 1'b0;
      HALTED      <= 1'b0;
      STEP_ACK    <= 1'b0;
      INSTR_DONE  <= 1'b0;
      INSTR_COUNT <= '0;
      UOP_ERR     <= 1'b0;
    end else begin
      INSTR_DONE <= 1'b0;
      STEP_ACK   <= 1'b0;

      // Flags are captured in every state and survive halt/step.
      if (READ_FLAGS) begin
        ZERO_FLAG <= ALU_ZERO;
        COUT_FLAG <= ALU_COUT;
      end

      case (state)
        S_IDLE: begin
          if (RUN) begin
            state <= S_RUN;
            uOP   <= UOP_FIRST;
          end else begin
            state  <= S_HALT;
            HALTED <= 1'b1;
          end
        end

        S_RUN, S_STEP: begin
          if (RESET_uOP) begin
            INSTR_DONE  <= 1'b1;
            INSTR_COUNT <= INSTR_COUNT + CNT_W'(1);
            if (state == S_STEP) begin
              STEP_ACK <= 1'b1;
              uOP      <= UOP_IDLE;
              state    <= S_HALT;
              HALTED   <= 1'b1;
            end else if (RUN) begin
              uOP <= UOP_FIRST;
            end else begin
              uOP    <= UOP_IDLE;
              state  <= S_HALT;
              HALTED <= 1'b1;
            end
          end else if (wd_trip) begin
`ifdef UOP_WATCHDOG_EN
            UOP_ERR <= 1'b1;
`endif
            // Abort without retiring: restart when running, park when stepping.
            if (state == S_STEP) begin
              uOP    <= UOP_IDLE;
              state  <= S_HALT;
              HALTED <= 1'b1;
            end else begin
              uOP <= UOP_FIRST;
            end
          end else begin
            uOP <= uOP + UOP_W'(1);
          end
        end

        S_HALT: begin
          if (RUN) begin
            state  <= S_RUN;
            uOP    <= UOP_FIRST;
            HALTED <= 1'b0;
          end else if (STEP_REQ) begin
            state  <= S_STEP;
            uOP    <= UOP_FIRST;
            HALTED <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          uOP   <= UOP_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uop_sequencer.md
Name: uop_sequencer

Overview:
- Drives the microoperation index uOP[2:0] consumed by the microcoded controller ROM.
- Responds to the controller's RESET_uOP and READ_FLAGS outputs.
- Latches the ALU zero and carry flags into ZERO_FLAG/COUT_FLAG, which feed back into the controller's jump decode.
- Provides run/halt control at instruction boundaries, a single-step handshake, and an instruction retire counter.

Parameters:
- CNT_W, 16, width of INSTR_COUNT.
- UOP_LIMIT, 6, highest uOP reachable without RESET_uOP before the watchdog fires (watchdog only, see Optional Feature).

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- RUN  input  1  level; 1 = free-run instructions, 0 = halt at next instruction boundary.
- STEP_REQ  input  1  single-cycle pulse; requests exactly one instruction while halted.
- RESET_uOP  input  1  from controller; current instruction ends this cycle.
- READ_FLAGS  input  1  from controller; capture ALU flags this cycle.
- ALU_ZERO  input  1  ALU zero result.
- ALU_COUT  input  1  ALU carry out.
- uOP  output  3  microoperation index to controller.
- ZERO_FLAG  output  1  registered zero flag.
- COUT_FLAG  output  1  registered carry flag.
- HALTED  output  1  1 while in HALT.
- STEP_ACK  output  1  one-cycle pulse when a stepped instruction retires.
- INSTR_DONE  output  1  one-cycle pulse per retired instruction.
- INSTR_COUNT  output  CNT_W  retired instruction count, wraps modulo 2^CNT_W.
- UOP_ERR  output  1  sticky watchdog error.

Behaviour:
- Reset values: uOP=3'b111, ZERO_FLAG=0, COUT_FLAG=0, HALTED=0, STEP_ACK=0, INSTR_DONE=0, INSTR_COUNT=0, UOP_ERR=0. State=S_IDLE.
- uOP=7 is the controller's idle/default microstate; the sequencer parks at 7 whenever not executing.

State machine (states S_IDLE, S_RUN, S_HALT, S_STEP):
- S_IDLE (one cycle after reset release): RUN=1 -> S_RUN, uOP<=0. RUN=0 -> S_HALT, uOP stays 7, HALTED<=1.
- S_RUN, RESET_uOP=1: instruction retires. INSTR_DONE<=1 for one cycle; INSTR_COUNT<=INSTR_COUNT+1.
  - If RUN=1: uOP<=0, stay in S_RUN.
  - If RUN=0: uOP<=7, go to S_HALT, HALTED<=1.
- S_RUN, RESET_uOP=0: uOP<=uOP+1.
- S_HALT: uOP held at 7; RESET_uOP is ignored.
  - RUN=1 -> S_RUN, uOP<=0, HALTED<=0.
  - Else STEP_REQ=1 -> S_STEP, uOP<=0, HALTED<=0.
  - RUN has priority over STEP_REQ.
- S_STEP: sequences exactly like S_RUN. On RESET_uOP=1: retire (INSTR_DONE, count), STEP_ACK<=1 for one cycle, uOP<=7, go to S_HALT, HALTED<=1. This happens regardless of RUN.
- STEP_REQ outside S_HALT is ignored; it is not queued.
- RUN deasserted mid-instruction never truncates the instruction; halting occurs only on RESET_uOP.
- Flags: any state, READ_FLAGS=1 at the edge -> ZERO_FLAG<=ALU_ZERO, COUT_FLAG<=ALU_COUT; otherwise hold. Flags are not cleared by halt or step.
- Latency: uOP changes one cycle after the controlling input is sampled. INSTR_DONE/STEP_ACK rise on the same edge that uOP returns to 0 or 7.
- INSTR_COUNT wraps from all-ones to 0 with no flag.
- Async RST mid-instruction: immediate return to reset values; flags and count are cleared.

Optional Feature:
- Macro: UOP_WATCHDOG_EN.
- Defined: in S_RUN/S_STEP, if uOP==UOP_LIMIT and RESET_uOP=0, then:
  - UOP_ERR<=1 (sticky until RST).
  - uOP<=0 in S_RUN; uOP<=7 and enter S_HALT in S_STEP.
  - INSTR_COUNT is not incremented, and INSTR_DONE/STEP_ACK are not asserted.
- Not defined: uOP increments modulo 8 with no limit; UOP_ERR is tied 0.

Test Plan:
- Reset release with RUN=1, controller returns RESET_uOP at uOP=3 -> uOP sequence 7,0,1,2,3,0; INSTR_DONE high one cycle; INSTR_COUNT=1.
- RUN dropped at uOP=1 of a 6-uOP ALU instruction (RESET_uOP at uOP=5) -> uOP continues 2..5, then 7; HALTED=1; count increments once.
- In HALT, STEP_REQ pulse, RESET_uOP at uOP=4 -> uOP 0..4 then 7; STEP_ACK and INSTR_DONE pulse together; HALTED back to 1. A second STEP_REQ mid-instruction is ignored.
- READ_FLAGS=1 with ALU_ZERO=1, ALU_COUT=0, then READ_FLAGS=0 with ALU_ZERO=0 -> ZERO_FLAG stays 1, COUT_FLAG stays 0.
- INSTR_COUNT preloaded near wrap via 65536 retired NOPs (RESET_uOP at uOP=2) -> count reads 0 after the 65536th instruction.
- UOP_WATCHDOG_EN defined, RESET_uOP held 0 -> uOP 0..6 then 0; UOP_ERR=1 and stays 1; INSTR_COUNT unchanged. Macro undefined -> uOP 0..7,0 and UOP_ERR=0.
